// File: rtl/pwr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwr_ctrl_pkg
// Description : Shared types and default delays for the PD1 power sequencer.
//               The state encoding is also visible in the status registers.
// Revision    : 1.0 - initial release
// ============================================================================
package pwr_ctrl_pkg;

    // Fixed encodings; software decodes o_pwr_state with these values
    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_SLP_REQ = 3'd1,
        ST_ISO     = 3'd2,
        ST_PD_OFF  = 3'd3,
        ST_SLEEP   = 3'd4,
        ST_WAKE    = 3'd5,
        ST_RST_REL = 3'd6
    } pwr_state_e;

    // Default delay constants
    localparam int DEF_ISO_DLY     = 4;
    localparam int DEF_RST_DLY     = 8;
    localparam int DEF_ACK_TIMEOUT = 255;
    localparam int DEF_PG_TIMEOUT  = 255;
    localparam int DEF_CNT_W       = 8;

    // Control outputs driven towards PD1 and the dcdc_enable stage
    typedef struct packed {
        logic dcdc_enable;
        logic sleep_req;
        logic pwr_on_ack;
        logic iso_en;
        logic pd1_clk_en;
        logic pd1_rst;
    } pwr_outs_t;

    // Output decode for each state
    function automatic pwr_outs_t state_outs(input pwr_state_e st);
        pwr_outs_t o;
        case (st)
            ST_ON:      o = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
            ST_SLP_REQ: o = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            ST_ISO:     o = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            ST_PD_OFF:  o = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
            ST_SLEEP:   o = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
            ST_WAKE:    o = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
            ST_RST_REL: o = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            default:    o = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pd1_pwr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pd1_pwr_sequencer
// Description : PD1 sleep/wake sequencer on the always-on clock. Drives the
//               PD1 handshake, isolation, clock gate and domain reset, plus
//               the raw DCDC enable / sleep request / power-on acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module pd1_pwr_sequencer
    import pwr_ctrl_pkg::*;
#(
    parameter int ISO_DLY     = DEF_ISO_DLY,
    parameter int RST_DLY     = DEF_RST_DLY,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int PG_TIMEOUT  = DEF_PG_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       i_aon_clk,
    input  logic       i_soc_pwr_on_rst,
    input  logic       i_sw_sleep_req,
    input  logic       i_wakeup_evt,
    input  logic       i_hw_sleep_ack,
    input  logic       i_pwr_good,
    output logic       o_dcdc_enable,
    output logic       o_sleep_req,
    output logic       o_pwr_on_ack,
    output logic       o_iso_en,
    output logic       o_pd1_clk_en,
    output logic       o_pd1_rst,
    output logic       o_timeout_err,
    output logic [2:0] o_pwr_state
);

    // Terminal counts: the counter reads 0 on the first cycle of a state
    localparam logic [CNT_W-1:0] c_ISO_LAST = CNT_W'(ISO_DLY - 1);
    localparam logic [CNT_W-1:0] c_RST_LAST = CNT_W'(RST_DLY - 1);
    localparam logic [CNT_W-1:0] c_ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_PG_LAST  = CNT_W'(PG_TIMEOUT - 1);

    pwr_state_e       r_state;
    pwr_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_wake_pend;
    logic             w_wake_pend_nxt;
    logic             w_timeout;
    logic             r_timeout_err;
    pwr_outs_t        r_outs;

    // Next-state, counter, pending-wake and timeout decode
    always_comb begin
        w_state_nxt     = r_state;
        w_timeout       = 1'b0;
        w_wake_pend_nxt = r_wake_pend;

        case (r_state)
            ST_ON: begin
                if (i_sw_sleep_req && !i_wakeup_evt) w_state_nxt = ST_SLP_REQ;
            end
            ST_SLP_REQ: begin
                // Wakeup wins over a same-cycle acknowledge
                if (i_wakeup_evt) begin
                    w_state_nxt = ST_ON;
                end else if (i_hw_sleep_ack) begin
                    w_state_nxt = ST_ISO;
                end else if (r_cnt == c_ACK_LAST) begin
                    w_state_nxt = ST_ON;
                    w_timeout   = 1'b1;
                end
            end
            ST_ISO: begin
                if (r_cnt == c_ISO_LAST) w_state_nxt = ST_PD_OFF;
            end
            ST_PD_OFF: begin
                if (!i_pwr_good) w_state_nxt = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (i_wakeup_evt || r_wake_pend) w_state_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                if (i_pwr_good) begin
                    w_state_nxt = ST_RST_REL;
                end else if (r_cnt == c_PG_LAST) begin
                    w_state_nxt = ST_SLEEP;
                    w_timeout   = 1'b1;
                end
            end
            ST_RST_REL: begin
                if (r_cnt == c_RST_LAST) w_state_nxt = ST_ON;
            end
            default: begin
                w_state_nxt = ST_ON;
            end
        endcase

        // Sleep is already committed in ISO/PD_OFF, so remember the event
        if (w_state_nxt == ST_WAKE) begin
            w_wake_pend_nxt = 1'b0;
        end else if ((r_state == ST_ISO || r_state == ST_PD_OFF) && i_wakeup_evt) begin
            w_wake_pend_nxt = 1'b1;
        end

        // Single shared counter: restart on state change, saturate otherwise
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if (r_state == ST_SLP_REQ || r_state == ST_ISO ||
                     r_state == ST_WAKE    || r_state == ST_RST_REL) begin
            w_cnt_nxt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
        end else begin
            w_cnt_nxt = '0;
        end
    end

    // State, counter and registered outputs; reset forces the ON outputs
    always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
        if (i_soc_pwr_on_rst) begin
            r_state       <= ST_ON;
            r_cnt         <= '0;
            r_wake_pend   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_outs        <= state_outs(ST_ON);
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_wake_pend   <= w_wake_pend_nxt;
            r_timeout_err <= w_timeout;
            r_outs        <= state_outs(w_state_nxt);
        end
    end

    assign o_dcdc_enable = r_outs.dcdc_enable;
    assign o_sleep_req   = r_outs.sleep_req;
    assign o_pwr_on_ack  = r_outs.pwr_on_ack;
    assign o_iso_en      = r_outs.iso_en;
    assign o_pd1_clk_en  = r_outs.pd1_clk_en;
    assign o_pd1_rst     = r_outs.pd1_rst;
    assign o_timeout_err = r_timeout_err;
    assign o_pwr_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pd1_pwr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pd1_pwr_sequencer
// Description : Directed self-checking bench for pd1_pwr_sequencer with a
//               per-cycle reference model and literal scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pd1_pwr_sequencer;

    localparam int ISO_DLY     = 4;
    localparam int RST_DLY     = 8;
    localparam int ACK_TIMEOUT = 10;
    localparam int PG_TIMEOUT  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_req = 1'b0, evt = 1'b0, ack = 1'b0, pg = 1'b1;
    logic dcdc, slp, pon_ack, iso, clk_en, pd1_rst, terr;
    logic [2:0] st;

    int checks = 0;
    int failures = 0;

    pd1_pwr_sequencer #(
        .ISO_DLY(ISO_DLY), .RST_DLY(RST_DLY),
        .ACK_TIMEOUT(ACK_TIMEOUT), .PG_TIMEOUT(PG_TIMEOUT), .CNT_W(8)
    ) dut (
        .i_aon_clk(clk), .i_soc_pwr_on_rst(rst),
        .i_sw_sleep_req(sw_req), .i_wakeup_evt(evt),
        .i_hw_sleep_ack(ack), .i_pwr_good(pg),
        .o_dcdc_enable(dcdc), .o_sleep_req(slp), .o_pwr_on_ack(pon_ack),
        .o_iso_en(iso), .o_pd1_clk_en(clk_en), .o_pd1_rst(pd1_rst),
        .o_timeout_err(terr), .o_pwr_state(st)
    );

    always #5 clk = ~clk;

    // Output table {dcdc, sleep_req, pwr_on_ack, iso, clk_en, pd1_rst}
    function automatic logic [5:0] tbl(input int s);
        case (s)
            0: return 6'b101010;
            1: return 6'b110010;
            2: return 6'b110100;
            3: return 6'b010101;
            4: return 6'b010101;
            5: return 6'b101101;
            6: return 6'b101111;
            default: return 6'b000000;
        endcase
    endfunction

    // Reference model: state plus unbounded time-in-state
    int m_st = 0;
    int m_dw = 0;
    bit m_pend = 0;
    bit m_terr = 0;
    int nx;
    bit to;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st <= 0; m_dw <= 0; m_pend <= 0; m_terr <= 0;
        end else begin
            nx = m_st; to = 0;
            case (m_st)
                0: if (sw_req && !evt) nx = 1;
                1: if (evt) nx = 0;
                   else if (ack) nx = 2;
                   else if (m_dw + 1 == ACK_TIMEOUT) begin nx = 0; to = 1; end
                2: if (m_dw + 1 == ISO_DLY) nx = 3;
                3: if (!pg) nx = 4;
                4: if (evt || m_pend) nx = 5;
                5: if (pg) nx = 6;
                   else if (m_dw + 1 == PG_TIMEOUT) begin nx = 4; to = 1; end
                6: if (m_dw + 1 == RST_DLY) nx = 0;
                default: nx = 0;
            endcase
            if (nx == 5) m_pend <= 0;
            else if ((m_st == 2 || m_st == 3) && evt) m_pend <= 1;
            m_dw   <= (nx != m_st) ? 0 : m_dw + 1;
            m_st   <= nx;
            m_terr <= to;
        end
    end

    // Monitors: per-state cycle counts, timeout pulses, rise times
    int cnt_st[8];
    int terr_cnt = 0;
    int cyc = 0;
    int iso_rise = -1, rst_rise = -1;
    logic iso_q = 0, rst_q = 0;

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ({st, dcdc, slp, pon_ack, iso, clk_en, pd1_rst, terr} !==
                {m_st[2:0], tbl(m_st), m_terr}) begin
                failures++;
                $display("FAIL model_cmp cyc=%0d actual st=%0d outs=%b terr=%b required st=%0d outs=%b terr=%b",
                         cyc, st, {dcdc, slp, pon_ack, iso, clk_en, pd1_rst}, terr,
                         m_st, tbl(m_st), m_terr);
            end
            cnt_st[st]++;
            if (terr) terr_cnt++;
            if (iso && !iso_q) iso_rise = cyc;
            if (pd1_rst && !rst_q) rst_rise = cyc;
        end
        iso_q = iso; rst_q = pd1_rst;
        cyc++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 8; i++) cnt_st[i] = 0;
        terr_cnt = 0;
    endtask

    task automatic wait_state(input int s, input int lim, input string nm);
        for (int i = 0; i < lim; i++) begin
            if (int'(st) == s) return;
            tick(1);
        end
        chk({nm, "_timeout"}, int'(st), s);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) cnt_st[i] = 0;
        tick(3);
        // Reset values
        chk("rst_state", int'(st), 0);
        chk("rst_outs", int'({dcdc, slp, pon_ack, iso, clk_en, pd1_rst}), int'(6'b101010));
        chk("rst_terr", int'(terr), 0);
        rst = 1'b0;
        tick(2);

        // Normal sleep: ack after 5 cycles, power-good drops 10 cycles into PD_OFF
        clr();
        sw_req = 1; tick(1);
        chk("s1_slp_req", int'(st), 1);
        tick(4); ack = 1; tick(1); ack = 0; sw_req = 0;
        chk("s1_iso", int'(st), 2);
        wait_state(3, 10, "s1_pd_off");
        chk("s1_dcdc_off", int'(dcdc), 0);
        tick(9); pg = 0; tick(1);
        chk("s1_sleep", int'(st), 4);
        chk("s1_iso_cycles", cnt_st[2], 4);
        chk("s1_iso_lead", rst_rise - iso_rise, 4);

        // Wake: event pulse, power-good 3 cycles later, reset release
        clr();
        evt = 1; tick(1); evt = 0;
        chk("s2_wake", int'(st), 5);
        tick(2); pg = 1;
        wait_state(0, 20, "s2_on");
        chk("s2_wake_cycles", cnt_st[5], 3);
        chk("s2_rst_rel_cycles", cnt_st[6], 8);
        chk("s2_iso_off", int'(iso), 0);
        tick(2);

        // Ack timeout after ACK_TIMEOUT cycles
        clr();
        sw_req = 1; tick(1); sw_req = 0;
        wait_state(0, 20, "s3_on");
        chk("s3_slp_cycles", cnt_st[1], ACK_TIMEOUT);
        tick(1);
        chk("s3_terr_pulses", terr_cnt, 1);
        chk("s3_sleep_req", int'(slp), 0);

        // Simultaneous wakeup and ack in SLP_REQ
        sw_req = 1; tick(1); sw_req = 0; tick(2);
        evt = 1; ack = 1; tick(1); evt = 0; ack = 0;
        chk("s4_wake_wins", int'(st), 0);
        tick(2);

        // Wakeup during ISO is remembered
        sw_req = 1; tick(1); sw_req = 0; tick(1);
        ack = 1; tick(1); ack = 0;
        tick(1); evt = 1; tick(1); evt = 0;
        wait_state(3, 10, "s4_pd_off");
        clr();
        pg = 0; tick(1);
        chk("s4_sleep", int'(st), 4);
        tick(1);
        chk("s4_pend_wake", int'(st), 5);
        chk("s4_sleep_cycles", cnt_st[4], 1);

        // Power-good timeout in WAKE
        clr();
        wait_state(4, 40, "s5_sleep");
        chk("s5_wake_cycles", cnt_st[5], PG_TIMEOUT - 1);
        tick(1);
        chk("s5_terr_pulses", terr_cnt, 1);
        chk("s5_dcdc", int'(dcdc), 0);
        tick(5);
        chk("s5_stay_sleep", int'(st), 4);

        // Wake back up, then sleep again and reset in PD_OFF
        evt = 1; tick(1); evt = 0; pg = 1;
        wait_state(0, 30, "s6_on");
        sw_req = 1; tick(1); sw_req = 0; tick(1);
        ack = 1; tick(1); ack = 0;
        wait_state(3, 10, "s6_pd_off");
        #2 rst = 1;
        #1;
        chk("s6_rst_state", int'(st), 0);
        chk("s6_rst_dcdc", int'(dcdc), 1);
        chk("s6_rst_iso", int'(iso), 0);
        tick(2); rst = 0;
        tick(3);
        chk("s6_after_rst", int'(st), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
